vdp_cpu_port: RTL and testbench

Parametrised CPU-side port of the VDP: the two-byte control latch, VRAM address auto-increment, the VDP register file, an optional colour RAM (CRAM) write path, a read-ahead buffer and the status/interrupt flags.
It extends the TMS9918 8-register interface to the SMS-style 16-register, 4-code interface with CRAM and a line interrupt.
It sits between the Z80 I/O decode and the video renderer/VRAM, and exposes a request/acknowledge VRAM handshake plus a wait output.

---
 rtl/vdp_pkg.sv | 19 +
 rtl/vdp_status_flags.sv | 55 +++++
 rtl/vdp_cpu_port.sv | 258 +++++++++++++++++++++++++
 tb/tb_vdp_cpu_port.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU port: access codes, VRAM handshake
// states and status byte bit positions.
package vdp_pkg;

  localparam logic [1:0] CODE_VRD  = 2'd0;
  localparam logic [1:0] CODE_VWR  = 2'd1;
  localparam logic [1:0] CODE_REG  = 2'd2;
  localparam logic [1:0] CODE_CRAM = 2'd3;

  typedef enum logic {
    VRAM_IDLE = 1'b0,
    VRAM_REQ  = 1'b1
  } vram_state_e;

  localparam int STAT_F_BIT   = 7;
  localparam int STAT_OVR_BIT = 6;
  localparam int STAT_COL_BIT = 5;

endpackage

// File: rtl/vdp_status_flags.sv
// Sticky status flags (frame, overflow, collision, line) with set-wins-over-clear
// behaviour and the registered active-low interrupt output.
module vdp_status_flags (
  input  logic clk,
  input  logic reset,
  input  logic frame_set,
  input  logic line_set,
  input  logic coll_set,
  input  logic ovr_set,
  input  logic clear,
  input  logic frame_irq_en,
  input  logic line_irq_en,
  output logic flag_f,
  output logic flag_ovr,
  output logic flag_col,
  output logic irq_n
);

  logic f_q, f_d;
  logic ovr_q, ovr_d;
  logic col_q, col_d;
  logic l_q, l_d;
  logic irq_n_q, irq_n_d;

  // A set pulse arriving in the same cycle as a status-read clear keeps the flag.
  always_comb begin
    f_d     = frame_set | (f_q & ~clear);
    ovr_d   = ovr_set   | (ovr_q & ~clear);
    col_d   = coll_set  | (col_q & ~clear);
    l_d     = line_set  | (l_q & ~clear);
    irq_n_d = ~((f_q & frame_irq_en) | (l_q & line_irq_en));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_q     <= 1'b0;
      ovr_q   <= 1'b0;
      col_q   <= 1'b0;
      l_q     <= 1'b0;
      irq_n_q <= 1'b1;
    end else begin
      f_q     <= f_d;
      ovr_q   <= ovr_d;
      col_q   <= col_d;
      l_q     <= l_d;
      irq_n_q <= irq_n_d;
    end
  end

  assign flag_f   = f_q;
  assign flag_ovr = ovr_q;
  assign flag_col = col_q;
  assign irq_n    = irq_n_q;

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU-side port of the VDP: two-byte control latch, auto-incrementing VRAM
// address, register file, CRAM write path, read-ahead buffer and VRAM handshake.
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int NUM_REGS = 16,
  parameter bit CRAM_EN  = 1'b1,
  parameter int CRAM_AW  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_sel,
  input  logic                  ctrl_sel,
  input  logic                  io_wr,
  input  logic                  io_rd,
  input  logic [7:0]            cpu_din,
  output logic [7:0]            cpu_dout,
  output logic                  vram_req,
  output logic                  vram_we,
  output logic [ADDR_W-1:0]     vram_addr,
  output logic [7:0]            vram_wdata,
  input  logic [7:0]            vram_rdata,
  input  logic                  vram_ack,
  output logic                  cram_we,
  output logic [CRAM_AW-1:0]    cram_addr,
  output logic [7:0]            cram_wdata,
  output logic [NUM_REGS*8-1:0] regs_flat,
  input  logic                  frame_set,
  input  logic                  line_set,
  input  logic                  coll_set,
  input  logic                  ovr_set,
  input  logic [4:0]            sprite5,
  output logic                  irq_n,
  output logic                  wait_n
);

  logic ctrl_wr, data_wr, data_rd, stat_rd;
  logic [ADDR_W-1:0] addr_q, addr_d, new_addr;
  logic [1:0] code_q, code_d;
  logic [7:0] first_q, first_d;
  logic flag_q, flag_d;
  logic [7:0] buffer_q, buffer_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

  logic acc_valid, acc_we;
  logic [ADDR_W-1:0] acc_addr;

  vram_state_e state_q, state_d;
  logic req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [7:0] req_wdata_q, req_wdata_d;
  logic pend_valid_q, pend_valid_d;
  logic pend_we_q, pend_we_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [7:0] pend_wdata_q, pend_wdata_d;

  logic cram_we_q, cram_we_d;
  logic [CRAM_AW-1:0] cram_addr_q, cram_addr_d;
  logic [7:0] cram_wdata_q, cram_wdata_d;

  logic flag_f, flag_ovr, flag_col;
  logic [7:0] status_byte;

  assign ctrl_wr  = io_wr & ctrl_sel;
  assign data_wr  = io_wr & data_sel;
  assign data_rd  = io_rd & data_sel;
  assign stat_rd  = io_rd & ctrl_sel;
  assign new_addr = ADDR_W'({cpu_din[5:0], first_q});

  // CPU-side decode: control latch, register writes, address stepping and the
  // single VRAM access (if any) this cycle wants to launch.
  always_comb begin
    addr_d       = addr_q;
    code_d       = code_q;
    first_d      = first_q;
    flag_d       = flag_q;
    buffer_d     = buffer_q;
    regs_d       = regs_q;
    cram_we_d    = 1'b0;
    cram_addr_d  = cram_addr_q;
    cram_wdata_d = cram_wdata_q;
    acc_valid    = 1'b0;
    acc_we       = 1'b0;
    acc_addr     = addr_q;

    if (state_q == VRAM_REQ && vram_ack && !req_we_q) begin
      buffer_d = vram_rdata;
    end

    if (ctrl_wr) begin
      if (!flag_q) begin
        first_d = cpu_din;
        flag_d  = 1'b1;
      end else begin
        flag_d = 1'b0;
        code_d = cpu_din[7:6];
        addr_d = new_addr;
        if (cpu_din[7:6] == CODE_VRD) begin
          acc_valid = 1'b1;
          acc_addr  = new_addr;
          addr_d    = new_addr + ADDR_W'(1);
        end
        if (cpu_din[7:6] == CODE_REG) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (cpu_din[3:0] == 4'(i)) regs_d[i] = first_q;
          end
        end
      end
    end else if (data_wr) begin
      flag_d   = 1'b0;
      buffer_d = cpu_din;
      addr_d   = addr_q + ADDR_W'(1);
      if (CRAM_EN && code_q == CODE_CRAM) begin
        cram_we_d    = 1'b1;
        cram_addr_d  = addr_q[CRAM_AW-1:0];
        cram_wdata_d = cpu_din;
      end else begin
        acc_valid = 1'b1;
        acc_we    = 1'b1;
      end
    end else if (data_rd) begin
      flag_d    = 1'b0;
      addr_d    = addr_q + ADDR_W'(1);
      acc_valid = 1'b1;
    end else if (stat_rd) begin
      flag_d = 1'b0;
    end
  end

  // VRAM handshake: one request in flight plus a one-entry pending slot that
  // is launched from IDLE on the cycle after the ack.
  always_comb begin
    state_d      = state_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    pend_valid_d = pend_valid_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;

    case (state_q)
      VRAM_IDLE: begin
        if (pend_valid_q) begin
          state_d      = VRAM_REQ;
          req_we_d     = pend_we_q;
          req_addr_d   = pend_addr_q;
          req_wdata_d  = pend_wdata_q;
          pend_valid_d = acc_valid;
          if (acc_valid) begin
            pend_we_d    = acc_we;
            pend_addr_d  = acc_addr;
            pend_wdata_d = cpu_din;
          end
        end else if (acc_valid) begin
          state_d     = VRAM_REQ;
          req_we_d    = acc_we;
          req_addr_d  = acc_addr;
          req_wdata_d = cpu_din;
        end
      end
      VRAM_REQ: begin
        if (vram_ack) state_d = VRAM_IDLE;
        if (acc_valid && !pend_valid_q) begin
          pend_valid_d = 1'b1;
          pend_we_d    = acc_we;
          pend_addr_d  = acc_addr;
          pend_wdata_d = cpu_din;
        end
      end
      default: state_d = VRAM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      code_q       <= '0;
      first_q      <= '0;
      flag_q       <= 1'b0;
      buffer_q     <= '0;
      state_q      <= VRAM_IDLE;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      pend_valid_q <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      cram_we_q    <= 1'b0;
      cram_addr_q  <= '0;
      cram_wdata_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      addr_q       <= addr_d;
      code_q       <= code_d;
      first_q      <= first_d;
      flag_q       <= flag_d;
      buffer_q     <= buffer_d;
      state_q      <= state_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      pend_valid_q <= pend_valid_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      cram_we_q    <= cram_we_d;
      cram_addr_q  <= cram_addr_d;
      cram_wdata_q <= cram_wdata_d;
      regs_q       <= regs_d;
    end
  end

  vdp_status_flags u_flags (
    .clk          (clk),
    .reset        (reset),
    .frame_set    (frame_set),
    .line_set     (line_set),
    .coll_set     (coll_set),
    .ovr_set      (ovr_set),
    .clear        (stat_rd),
    .frame_irq_en (regs_q[1][5]),
    .line_irq_en  (regs_q[0][4]),
    .flag_f       (flag_f),
    .flag_ovr     (flag_ovr),
    .flag_col     (flag_col),
    .irq_n        (irq_n)
  );

  // Low five status bits report the fifth-sprite index only when OVR is set.
  always_comb begin
    status_byte               = {3'b000, flag_ovr ? sprite5 : 5'h1F};
    status_byte[STAT_F_BIT]   = flag_f;
    status_byte[STAT_OVR_BIT] = flag_ovr;
    status_byte[STAT_COL_BIT] = flag_col;
    if (data_sel)      cpu_dout = buffer_q;
    else if (ctrl_sel) cpu_dout = status_byte;
    else               cpu_dout = 8'h00;
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_flat[8*i +: 8] = regs_q[i];
  end

  assign vram_req   = (state_q == VRAM_REQ);
  assign vram_we    = req_we_q;
  assign vram_addr  = req_addr_q;
  assign vram_wdata = req_wdata_q;
  assign wait_n     = ~pend_valid_q;
  assign cram_we    = cram_we_q;
  assign cram_addr  = cram_addr_q;
  assign cram_wdata = cram_wdata_q;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Scoreboard bench for vdp_cpu_port: a behavioural model predicts VRAM/CRAM
// transactions and read data; a monitor compares them as the DUT presents them.
module tb_vdp_cpu_port;

  localparam int ASIZE = 16384;
  localparam int K_NONE = 0, K_CW = 1, K_DW = 2, K_DR = 3, K_SR = 4;

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [7:0]  data;
  } vtx_t;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } ctx_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         data_sel = 1'b0, ctrl_sel = 1'b0, io_wr = 1'b0, io_rd = 1'b0;
  logic [7:0]   cpu_din = 8'h00;
  logic [7:0]   cpu_dout;
  logic         vram_req, vram_we;
  logic [13:0]  vram_addr;
  logic [7:0]   vram_wdata;
  logic [7:0]   vram_rdata;
  logic         vram_ack;
  logic         cram_we;
  logic [4:0]   cram_addr;
  logic [7:0]   cram_wdata;
  logic [127:0] regs_flat;
  logic         frame_set = 1'b0, line_set = 1'b0, coll_set = 1'b0, ovr_set = 1'b0;
  logic [4:0]   sprite5 = 5'h00;
  logic         irq_n, wait_n;

  int total = 0;
  int bad = 0;
  int force_delay = -1;

  logic [7:0] mem [ASIZE];
  logic [7:0] model_mem [ASIZE];

  vtx_t       exp_vram [$];
  ctx_t       exp_cram [$];
  logic [7:0] exp_rd [$];

  // Reference model state
  logic       m_flag;
  logic [7:0] m_first;
  logic [1:0] m_code;
  int         m_addr;
  logic [7:0] m_buf;
  logic [7:0] m_regs [16];
  logic       m_f, m_ovr, m_col, m_l;

  vdp_cpu_port #(
    .ADDR_W   (14),
    .NUM_REGS (16),
    .CRAM_EN  (1'b1),
    .CRAM_AW  (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_sel   (data_sel),
    .ctrl_sel   (ctrl_sel),
    .io_wr      (io_wr),
    .io_rd      (io_rd),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .vram_req   (vram_req),
    .vram_we    (vram_we),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata),
    .vram_ack   (vram_ack),
    .cram_we    (cram_we),
    .cram_addr  (cram_addr),
    .cram_wdata (cram_wdata),
    .regs_flat  (regs_flat),
    .frame_set  (frame_set),
    .line_set   (line_set),
    .coll_set   (coll_set),
    .ovr_set    (ovr_set),
    .sprite5    (sprite5),
    .irq_n      (irq_n),
    .wait_n     (wait_n)
  );

  always #5 clk = ~clk;

  // Watchdog: the run must always end on its own.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] modelFlat();
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  function automatic logic modelIrqN();
    return !((m_f && m_regs[1][5]) || (m_l && m_regs[0][4]));
  endfunction

  task automatic modelReset();
    m_flag = 1'b0; m_first = 8'h00; m_code = 2'd0; m_addr = 0; m_buf = 8'h00;
    m_f = 1'b0; m_ovr = 1'b0; m_col = 1'b0; m_l = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
  endtask

  function automatic vtx_t mkv(input logic we, input int a, input logic [7:0] d);
    vtx_t v;
    v.we = we; v.addr = 14'(a); v.data = d;
    return v;
  endfunction

  // Behavioural model of one CPU strobe, evaluated at the clock edge that samples it.
  task automatic modelStep(input int kind, input logic [7:0] d, input logic [3:0] sets);
    ctx_t c;
    case (kind)
      K_CW: begin
        if (!m_flag) begin
          m_first = d;
          m_flag  = 1'b1;
        end else begin
          m_flag = 1'b0;
          m_code = d[7:6];
          m_addr = (int'(d[5:0]) * 256 + int'(m_first)) % ASIZE;
          if (m_code == 2'd0) begin
            exp_vram.push_back(mkv(1'b0, m_addr, 8'h00));
            m_buf  = model_mem[m_addr];
            m_addr = (m_addr + 1) % ASIZE;
          end
          if (m_code == 2'd2) m_regs[d[3:0]] = m_first;
        end
      end
      K_DW: begin
        m_flag = 1'b0;
        m_buf  = d;
        if (m_code == 2'd3) begin
          c.addr = 5'(m_addr % 32);
          c.data = d;
          exp_cram.push_back(c);
        end else begin
          exp_vram.push_back(mkv(1'b1, m_addr, d));
          model_mem[m_addr] = d;
        end
        m_addr = (m_addr + 1) % ASIZE;
      end
      K_DR: begin
        exp_rd.push_back(m_buf);
        m_flag = 1'b0;
        exp_vram.push_back(mkv(1'b0, m_addr, 8'h00));
        m_buf  = model_mem[m_addr];
        m_addr = (m_addr + 1) % ASIZE;
      end
      K_SR: begin
        exp_rd.push_back({m_f, m_ovr, m_col, m_ovr ? sprite5 : 5'h1F});
        m_flag = 1'b0;
      end
      default: ;
    endcase
    m_f   = sets[3] | (m_f   & (kind != K_SR));
    m_l   = sets[2] | (m_l   & (kind != K_SR));
    m_col = sets[1] | (m_col & (kind != K_SR));
    m_ovr = sets[0] | (m_ovr & (kind != K_SR));
  endtask

  task automatic driveStrobe(input int kind, input logic [7:0] d, input logic [3:0] sets);
    @(posedge clk); #1;
    cpu_din  = d;
    sprite5  = 5'($urandom);
    {frame_set, line_set, coll_set, ovr_set} = sets;
    ctrl_sel = (kind == K_CW || kind == K_SR);
    data_sel = (kind == K_DW || kind == K_DR);
    io_wr    = (kind == K_CW || kind == K_DW);
    io_rd    = (kind == K_DR || kind == K_SR);
    modelStep(kind, d, sets);
    @(posedge clk); #1;
    {frame_set, line_set, coll_set, ovr_set} = 4'b0000;
    ctrl_sel = 1'b0; data_sel = 1'b0; io_wr = 1'b0; io_rd = 1'b0;
  endtask

  task automatic waitIdle();
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (!vram_req && wait_n) quiet++;
      else quiet = 0;
    end
    checkOutput("idle_reached", 128'(quiet >= 3), 128'(1));
  endtask

  task automatic checkSteady();
    checkOutput("regs_flat", regs_flat, modelFlat());
    checkOutput("irq_n", 128'(irq_n), 128'(modelIrqN()));
    checkOutput("wait_n_idle", 128'(wait_n), 128'(1));
    checkOutput("cpu_dout_nosel", 128'(cpu_dout), 128'(0));
    checkOutput("cram_we_idle", 128'(cram_we), 128'(0));
  endtask

  task automatic applyStimulus(input int kind, input logic [7:0] d, input logic [3:0] sets);
    driveStrobe(kind, d, sets);
    waitIdle();
    checkSteady();
  endtask

  // VRAM responder: acks each request after a delay, backed by its own memory.
  initial begin : responder
    int  cnt;
    bit  busy;
    cnt = 0; busy = 0;
    vram_ack = 1'b0; vram_rdata = 8'h00;
    forever begin
      @(negedge clk);
      vram_ack = 1'b0;
      if (reset) begin
        busy = 0;
      end else begin
        if (vram_req && !busy) begin
          busy = 1;
          cnt  = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
        end
        if (busy) begin
          if (cnt == 0) begin
            vram_ack = 1'b1;
            if (vram_we) mem[vram_addr] = vram_wdata;
            else vram_rdata = mem[vram_addr];
            busy = 0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a transaction.
  initial begin : monitor
    bit   prev_req;
    vtx_t e;
    ctx_t c;
    logic [7:0] r;
    prev_req = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 0;
      end else begin
        if (vram_req && !prev_req) begin
          if (exp_vram.size() == 0) begin
            checkOutput("vram_unexpected_req", 128'(vram_addr), 128'(0) - 128'(1));
          end else begin
            e = exp_vram.pop_front();
            checkOutput("vram_txn", 128'({vram_we, vram_addr, vram_we ? vram_wdata : 8'h00}),
                        128'({e.we, e.addr, e.we ? e.data : 8'h00}));
          end
        end
        prev_req = vram_req;
        if (cram_we) begin
          if (exp_cram.size() == 0) begin
            checkOutput("cram_unexpected_we", 128'(cram_addr), 128'(0) - 128'(1));
          end else begin
            c = exp_cram.pop_front();
            checkOutput("cram_txn", 128'({cram_addr, cram_wdata}), 128'({c.addr, c.data}));
          end
        end
        if (io_rd && (data_sel || ctrl_sel)) begin
          if (exp_rd.size() == 0) begin
            checkOutput("rd_unexpected", 128'(cpu_dout), 128'(0) - 128'(1));
          end else begin
            r = exp_rd.pop_front();
            checkOutput(data_sel ? "data_read" : "status_read", 128'(cpu_dout), 128'(r));
          end
        end
      end
    end
  end

  initial begin : stimulus
    int   a0, lowcnt;
    logic [7:0] save0, save1;
    logic [3:0] s;
    int   k, pick;

    for (int i = 0; i < ASIZE; i++) begin
      mem[i]       = 8'($urandom);
      model_mem[i] = mem[i];
    end
    mem[0] = 8'h5A;
    model_mem[0] = 8'h5A;
    modelReset();

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_vram_req", 128'(vram_req), 128'(0));
    checkOutput("rst_vram_we", 128'(vram_we), 128'(0));
    checkOutput("rst_irq_n", 128'(irq_n), 128'(1));
    checkSteady();

    $display("[TB] address load and data write");
    applyStimulus(K_CW, 8'h34, 4'b0000);
    applyStimulus(K_CW, 8'h52, 4'b0000);
    applyStimulus(K_DW, 8'hAA, 4'b0000);
    applyStimulus(K_DR, 8'h00, 4'b0000);

    $display("[TB] register writes");
    applyStimulus(K_CW, 8'h80, 4'b0000);
    applyStimulus(K_CW, 8'h81, 4'b0000);
    checkOutput("reg1_value", 128'(regs_flat[15:8]), 128'(8'h80));
    applyStimulus(K_CW, 8'h55, 4'b0000);
    applyStimulus(K_CW, 8'h8F, 4'b0000);

    $display("[TB] read-ahead");
    applyStimulus(K_CW, 8'h00, 4'b0000);
    applyStimulus(K_CW, 8'h00, 4'b0000);
    applyStimulus(K_DR, 8'h00, 4'b0000);

    $display("[TB] address wrap and CRAM");
    applyStimulus(K_CW, 8'hFF, 4'b0000);
    applyStimulus(K_CW, 8'h7F, 4'b0000);
    applyStimulus(K_DW, 8'h3C, 4'b0000);
    applyStimulus(K_DW, 8'hC3, 4'b0000);
    applyStimulus(K_CW, 8'h23, 4'b0000);
    applyStimulus(K_CW, 8'hC0, 4'b0000);
    applyStimulus(K_DW, 8'h11, 4'b0000);

    $display("[TB] frame interrupt and status");
    applyStimulus(K_CW, 8'h20, 4'b0000);
    applyStimulus(K_CW, 8'h81, 4'b0000);
    driveStrobe(K_NONE, 8'h00, 4'b1000);
    @(negedge clk);
    checkOutput("irq_n_latency", 128'(irq_n), 128'(1));
    @(negedge clk);
    checkOutput("irq_n_asserted", 128'(irq_n), 128'(0));
    applyStimulus(K_SR, 8'h00, 4'b0000);
    driveStrobe(K_NONE, 8'h00, 4'b1000);
    applyStimulus(K_SR, 8'h00, 4'b1000);
    applyStimulus(K_SR, 8'h00, 4'b0000);
    applyStimulus(K_SR, 8'h00, 4'b0000);

    $display("[TB] wait_n with delayed ack");
    force_delay = 5;
    applyStimulus(K_CW, 8'h00, 4'b0000);
    applyStimulus(K_CW, 8'h50, 4'b0000);
    driveStrobe(K_DW, 8'h21, 4'b0000);
    driveStrobe(K_DW, 8'h22, 4'b0000);
    @(negedge clk);
    checkOutput("wait_n_low", 128'(wait_n), 128'(0));
    lowcnt = 0;
    while (!wait_n && lowcnt < 20) begin
      @(negedge clk);
      lowcnt++;
    end
    checkOutput("wait_n_released", 128'(wait_n), 128'(1));
    checkOutput("pending_issued", 128'(vram_req), 128'(1));
    waitIdle();
    checkSteady();

    $display("[TB] reset during request");
    a0    = m_addr;
    save0 = model_mem[a0];
    save1 = model_mem[(a0 + 1) % ASIZE];
    driveStrobe(K_DW, 8'h31, 4'b0000);
    driveStrobe(K_DW, 8'h32, 4'b0000);
    @(negedge clk);
    checkOutput("req_before_reset", 128'(vram_req), 128'(1));
    checkOutput("wait_n_before_reset", 128'(wait_n), 128'(0));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_vram.delete();
    model_mem[(a0 + 1) % ASIZE] = save1;
    model_mem[a0] = save0;
    modelReset();
    @(negedge clk);
    checkOutput("abort_vram_req", 128'(vram_req), 128'(0));
    checkOutput("abort_vram_we", 128'(vram_we), 128'(0));
    checkOutput("abort_irq_n", 128'(irq_n), 128'(1));
    checkSteady();
    force_delay = -1;
    waitIdle();
    applyStimulus(K_DR, 8'h00, 4'b0000);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 300; n++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 35)      k = K_CW;
      else if (pick < 60) k = K_DW;
      else if (pick < 80) k = K_DR;
      else if (pick < 90) k = K_SR;
      else                k = K_NONE;
      s = 4'b0000;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) s[b] = 1'b1;
      applyStimulus(k, 8'($urandom), s);
    end

    checkOutput("vram_queue_drained", 128'(exp_vram.size()), 128'(0));
    checkOutput("cram_queue_drained", 128'(exp_cram.size()), 128'(0));
    checkOutput("read_queue_drained", 128'(exp_rd.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
